pdm_cic_decimator: RTL and testbench
====================================

# pdm_cic_decimator

Parametrised N-stage CIC decimator converting a 1-bit PDM/sigma-delta bitstream into signed PCM words at 1/R of the bit rate, with rounding, saturation and a valid/ready output handshake. It is the next-generation replacement for the fixed 8-bit filter/decimator in the audio front end. Decimation ratio, filter order and output width are configurable. Sample-enable gating and overrun detection are added.

## Interface

Parameters:
- R, 64, decimation ratio; power of two, 4..256
- N, 3, CIC order (integrator/comb pairs), 1..5
- OUT_W, 8, output word width (signed), 4..16; must satisfy OUT_W-1 ≤ N·log2(R)

Ports:
- CLK  in  1  bit clock; all state on rising edge
- RST  in  1  reset; asynchronous, active-low
- EN  in  1  input sample enable; IN consumed only when EN=1
- IN  in  1  PDM bit; 1 → +1, 0 → −1
- OUT  out  OUT_W  signed two's-complement PCM sample
- OUT_VALID  out  1  OUT holds an unconsumed sample
- OUT_READY  in  1  consumer accepts OUT when OUT_VALID=1
- OVF  out  1  sticky overrun flag

## Operation

- Internal width: B = N·log2(R) + 2 for all integrators and combs. Integrators wrap modulo 2^B by design; comb differences are exact.
- Integrators run only on edges with EN=1. The cascade is combinational within a cycle: I1' = I1 + x, Ik' = Ik + I(k−1)'.
- Phase counter: 0..R−1, advances only with EN=1 and wraps to 0.
- Decimation edge: EN=1 and phase = R−1. IN_N' is captured into the comb input register and a valid token is launched.
- Comb stages are registered, one per cycle: Ck = c(k−1) − D_k. D_k is updated only when the token passes. Comb logic is independent of EN.
- Scaling: y = comb output, range ±R^N.
  - SHIFT = N·log2(R) − (OUT_W−1).
  - q = (y + 2^(SHIFT−1)) >>> SHIFT when SHIFT>0; round half up, arithmetic shift.
  - q is saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Output register:
  - A new scaled sample loads OUT and sets OUT_VALID=1.
  - A handshake completes on an edge with OUT_VALID=1 and OUT_READY=1. OUT_VALID clears unless a new sample loads on that same edge.
  - New sample with OUT_VALID=1 and OUT_READY=0: the old sample is overwritten, OUT_VALID stays 1, and OVF is set.
  - New sample on an edge with OUT_READY=1: the old sample counts as consumed. No OVF. OUT_VALID stays 1 with the new data.
- OVF clears only on reset.
- No FSM beyond the phase counter and the N+1-deep token shift register.

## Timing

- Reset (RST=0, asynchronous) zeroes all integrators, combs, delay lines, the phase counter and the token pipeline. It also sets OUT=0, OUT_VALID=0, OVF=0.
- Reset mid-block discards the partial block and any in-flight token. The first post-reset output requires R fresh enabled bits.
- Latency: the decimation edge is e. OUT and OUT_VALID update on edge e+N+1, regardless of EN during those cycles.
- Output cadence: one sample per R enabled bits. With EN held 1, exactly one sample every R cycles.
- Transient: the first N outputs after reset reflect zeroed comb history. Outputs from index N (0-based) onward are steady-state.
- EN=0 freezes integrators and phase only. An in-flight token still completes.
- OUT is stable while OUT_VALID=1 and OUT_READY=0, unless an overrun overwrite occurs.

## Test plan

- Defaults, EN=1, OUT_READY=1, IN all ones → outputs ≥ index 3 are 127 (saturated from +128). A sample arrives every 64 cycles, OVF=0.
- IN all zeros → steady-state OUT = −128 (exact, no saturation).
- IN alternating 1,0 → steady-state OUT = 0. IN pattern 1,1,1,0 repeating → steady-state OUT = 64.
- Latency check: after reset, EN=1 from the first edge → first OUT_VALID on edge 64+3+1 relative to the first sampling edge. EN low for 100 cycles mid-block → next OUT_VALID delayed by exactly 100 cycles, value unchanged versus the ungated run.
- OUT_READY=0 across two output periods → OVF=1 after the second sample, OUT equals the newest sample. OUT_READY=1 on the same edge as a new sample → OVF stays 0.
- RST pulsed low mid-block (phase 30) → all outputs 0 immediately, OVF=0. The next OUT_VALID comes 64 enabled bits plus 4 cycles after release. Repeat with R=16, N=2, OUT_W=6: all-ones gives 31.

Source files
------------

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: N-stage CIC decimator, 1-bit PDM in, signed PCM out.
// Round-half-up scaling, saturation, valid/ready output with sticky overrun.
module pdm_cic_decimator #(
  parameter int R     = 64,
  parameter int N     = 3,
  parameter int OUT_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    IN,
  output logic signed [OUT_W-1:0] OUT,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    OVF
);
  localparam int L     = $clog2(R);
  localparam int B     = N * L + 2;
  localparam int SHIFT = N * L - (OUT_W - 1);

  typedef logic signed [B-1:0] acc_t;

  localparam acc_t ONE  = acc_t'(1);
  localparam acc_t MAXV = (ONE <<< (OUT_W - 1)) - ONE;
  localparam acc_t MINV = -(ONE <<< (OUT_W - 1));

  acc_t             integ_q [N];
  acc_t             integ_d [N];
  acc_t             comb_q  [N];
  acc_t             comb_d  [N];
  acc_t             dly_q   [N];
  acc_t             dly_d   [N];
  acc_t             src     [N];
  acc_t             cin_q, cin_d;
  acc_t             x_in, acc;
  acc_t             y, rnd;
  logic [L-1:0]     phase_q, phase_d;
  logic [N:0]       tok_q, tok_d;
  logic             dec;
  logic [OUT_W-1:0] sat;
  logic [OUT_W-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  // Integrator cascade sees this cycle's updated value of the stage before.
  always_comb begin
    x_in = IN ? ONE : '1;
    acc  = x_in;
    for (int k = 0; k < N; k++) begin
      acc        = integ_q[k] + acc;
      integ_d[k] = EN ? acc : integ_q[k];
    end
    dec     = EN && (phase_q == '1);
    phase_d = EN ? phase_q + 1'b1 : phase_q;
    cin_d   = dec ? acc : cin_q;
    tok_d   = {tok_q[N-1:0], dec};
  end

  always_comb begin
    src[0] = cin_q;
    for (int k = 1; k < N; k++) begin
      src[k] = comb_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      comb_d[k] = comb_q[k];
      dly_d[k]  = dly_q[k];
      if (tok_q[k]) begin
        comb_d[k] = src[k] - dly_q[k];
        dly_d[k]  = src[k];
      end
    end
  end

  assign y = comb_q[N-1];

  if (SHIFT > 0) begin : g_round
    localparam acc_t HALF = ONE <<< (SHIFT - 1);
    assign rnd = (y + HALF) >>> SHIFT;
  end else begin : g_pass
    assign rnd = y;
  end

  always_comb begin
    sat = rnd[OUT_W-1:0];
    if (rnd > MAXV) begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (rnd < MINV) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end
    out_d = out_q;
    vld_d = vld_q;
    ovf_d = ovf_q;
    if (vld_q && OUT_READY) begin
      vld_d = 1'b0;
    end
    // A fresh sample wins over a handshake; losing an unread one is an overrun.
    if (tok_q[N]) begin
      out_d = sat;
      vld_d = 1'b1;
      if (vld_q && !OUT_READY) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      cin_q   <= '0;
      phase_q <= '0;
      tok_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
      cin_q   <= cin_d;
      phase_q <= phase_d;
      tok_q   <= tok_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = vld_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: random and pattern stimulus against a boxcar^N
// convolution model of the decimator, plus handshake/reset scenarios.
module tb_pdm_cic_decimator;
  logic              CLK;
  logic              rst_n, en, in_b, rdy;
  logic signed [7:0] out;
  logic              vld, ovf;
  logic              rst2, en2, in2, rdy2;
  logic signed [5:0] out2;
  logic              vld2, ovf2;
  int                n_run, n_fail;
  int                hist[$];
  int                hist2[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  pdm_cic_decimator #(.R(64), .N(3), .OUT_W(8)) dut (
    .CLK(CLK), .RST(rst_n), .EN(en), .IN(in_b),
    .OUT(out), .OUT_VALID(vld), .OUT_READY(rdy), .OVF(ovf)
  );

  pdm_cic_decimator #(.R(16), .N(2), .OUT_W(6)) dut2 (
    .CLK(CLK), .RST(rst2), .EN(en2), .IN(in2),
    .OUT(out2), .OUT_VALID(vld2), .OUT_READY(rdy2), .OVF(ovf2)
  );

  // Output m is the input (zero before reset) filtered by an R-long boxcar
  // applied N times, taken at the last bit of block m.
  function automatic longint model_y(input int r, input int n, input int m,
                                     input int hs[$]);
    longint h[$];
    longint t[$];
    longint y;
    int     last;
    h.push_back(1);
    for (int s = 0; s < n; s++) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) begin
        longint a;
        a = 0;
        for (int j = 0; j < r; j++) begin
          if (i - j >= 0 && i - j < h.size()) a += h[i-j];
        end
        t.push_back(a);
      end
      h = t;
    end
    last = m * r + r - 1;
    y = 0;
    for (int j = 0; j < h.size(); j++) begin
      if (last - j >= 0 && last - j < hs.size()) y += h[j] * hs[last-j];
    end
    return y;
  endfunction

  function automatic int model_q(input longint y, input int s, input int w);
    longint q, hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (s > 0) q = (y + (longint'(1) << (s - 1))) >>> s;
    else q = y;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  function automatic int exp1(input int m);
    return model_q(model_y(64, 3, m, hist), 11, 8);
  endfunction

  function automatic bit pat(input int kind, input int i);
    case (kind)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2) == 0;
      default: return (i % 4) != 3;
    endcase
  endfunction

  task automatic tick(input bit e, input bit b, input bit r);
    en = e; in_b = b; rdy = r;
    @(posedge CLK);
    if (e) hist.push_back(b ? 1 : -1);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; in_b = 1'b0; rdy = 1'b1;
    hist.delete();
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; in_b = 1'b0; rdy = 1'b1;
    rst2 = 1'b0; en2 = 1'b0; in2 = 1'b0; rdy2 = 1'b1;
    #2;
    n_run++;
    if (out !== 8'sd0) begin
      n_fail++; $display("FAIL reset_out: got %0d want 0", out);
    end
    n_run++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", vld);
    end
    n_run++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_pattern(input int kind, input int steady);
    int idx, last;
    do_reset();
    idx = 0; last = 0;
    for (int t = 1; t <= 520; t++) begin
      tick(1'b1, pat(kind, t - 1), 1'b1);
      if (vld) begin
        int want;
        want = exp1(idx);
        n_run++;
        if (int'(out) !== want) begin
          n_fail++;
          $display("FAIL pat%0d_model[%0d]: got %0d want %0d", kind, idx, out, want);
        end
        if (idx >= 3) begin
          n_run++;
          if (int'(out) !== steady) begin
            n_fail++;
            $display("FAIL pat%0d_steady[%0d]: got %0d want %0d", kind, idx, out, steady);
          end
        end
        n_run++;
        if (idx == 0) begin
          if (t !== 68) begin
            n_fail++; $display("FAIL pat%0d_latency: got %0d want 68", kind, t);
          end
        end else if (t - last !== 64) begin
          n_fail++; $display("FAIL pat%0d_cadence: got %0d want 64", kind, t - last);
        end
        last = t;
        idx++;
      end
    end
    n_run++;
    if (idx !== 8) begin
      n_fail++; $display("FAIL pat%0d_count: got %0d want 8", kind, idx);
    end
    n_run++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL pat%0d_ovf: got %b want 0", kind, ovf);
    end
  endtask

  task automatic test_random;
    int idx;
    do_reset();
    idx = 0;
    for (int t = 1; t <= 1208; t++) begin
      if (t <= 1200)
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b1);
      else
        tick(1'b0, 1'b0, 1'b1);
      if (vld) begin
        int want;
        want = exp1(idx);
        n_run++;
        if (int'(out) !== want) begin
          n_fail++;
          $display("FAIL rand_model[%0d]: got %0d want %0d", idx, out, want);
        end
        idx++;
      end
    end
    n_run++;
    if (idx !== hist.size() / 64) begin
      n_fail++; $display("FAIL rand_count: got %0d want %0d", idx, hist.size() / 64);
    end
  endtask

  task automatic test_en_gap;
    int first;
    do_reset();
    first = 0;
    for (int t = 1; t <= 400 && first == 0; t++) begin
      tick(!(t > 30 && t <= 130), $urandom_range(0, 1) == 1, 1'b1);
      if (vld) begin
        int want;
        first = t;
        want = exp1(0);
        n_run++;
        if (int'(out) !== want) begin
          n_fail++; $display("FAIL gap_value: got %0d want %0d", out, want);
        end
      end
    end
    n_run++;
    if (first !== 168) begin
      n_fail++; $display("FAIL gap_latency: got %0d want 168", first);
    end
  endtask

  task automatic test_overrun;
    logic signed [7:0] saved;
    do_reset();
    saved = '0;
    for (int t = 1; t <= 132; t++) begin
      tick(1'b1, $urandom_range(0, 1) == 1, 1'b0);
      if (t == 68) begin
        n_run++;
        if (vld !== 1'b1 || ovf !== 1'b0 || int'(out) !== exp1(0)) begin
          n_fail++;
          $display("FAIL ovr_first: got v=%b o=%b d=%0d want v=1 o=0 d=%0d",
                   vld, ovf, out, exp1(0));
        end
        saved = out;
      end else if (t == 100) begin
        n_run++;
        if (vld !== 1'b1 || out !== saved) begin
          n_fail++;
          $display("FAIL ovr_hold: got v=%b d=%0d want v=1 d=%0d", vld, out, saved);
        end
      end else if (t == 131) begin
        n_run++;
        if (ovf !== 1'b0) begin
          n_fail++; $display("FAIL ovr_early: got %b want 0", ovf);
        end
      end else if (t == 132) begin
        n_run++;
        if (ovf !== 1'b1 || vld !== 1'b1 || int'(out) !== exp1(1)) begin
          n_fail++;
          $display("FAIL ovr_second: got v=%b o=%b d=%0d want v=1 o=1 d=%0d",
                   vld, ovf, out, exp1(1));
        end
      end
    end
    tick(1'b0, 1'b0, 1'b1);
    n_run++;
    if (vld !== 1'b0 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovr_sticky: got v=%b o=%b want v=0 o=1", vld, ovf);
    end
  endtask

  task automatic test_ready_same_edge;
    do_reset();
    for (int t = 1; t <= 133; t++) begin
      tick(1'b1, $urandom_range(0, 1) == 1, t >= 132);
      if (t == 132) begin
        n_run++;
        if (ovf !== 1'b0 || vld !== 1'b1 || int'(out) !== exp1(1)) begin
          n_fail++;
          $display("FAIL same_edge: got v=%b o=%b d=%0d want v=1 o=0 d=%0d",
                   vld, ovf, out, exp1(1));
        end
      end else if (t == 133) begin
        n_run++;
        if (vld !== 1'b0 || ovf !== 1'b0) begin
          n_fail++; $display("FAIL same_edge_drain: got v=%b o=%b want v=0 o=0", vld, ovf);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int first;
    do_reset();
    for (int t = 1; t <= 158; t++) tick(1'b1, 1'b1, 1'b0);
    n_run++;
    if (ovf !== 1'b1 || vld !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got v=%b o=%b want v=1 o=1", vld, ovf);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (out !== 8'sd0 || vld !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_clear: got d=%0d v=%b o=%b want 0 0 0", out, vld, ovf);
    end
    hist.delete();
    @(negedge CLK);
    rst_n = 1'b1;
    first = 0;
    for (int t = 1; t <= 200 && first == 0; t++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (vld) begin
        first = t;
        n_run++;
        if (int'(out) !== exp1(0)) begin
          n_fail++; $display("FAIL rmid_value: got %0d want %0d", out, exp1(0));
        end
      end
    end
    n_run++;
    if (first !== 68) begin
      n_fail++; $display("FAIL rmid_latency: got %0d want 68", first);
    end
    n_run++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_small_config;
    int idx, last;
    n_run++;
    if (out2 !== 6'sd0 || vld2 !== 1'b0 || ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL small_reset: got d=%0d v=%b o=%b want 0 0 0", out2, vld2, ovf2);
    end
    rst2 = 1'b1;
    hist2.delete();
    idx = 0; last = 0;
    for (int t = 1; t <= 130; t++) begin
      en2 = 1'b1; in2 = 1'b1; rdy2 = 1'b1;
      @(posedge CLK);
      hist2.push_back(1);
      #1;
      if (vld2) begin
        int want;
        want = model_q(model_y(16, 2, idx, hist2), 3, 6);
        n_run++;
        if (int'(out2) !== want) begin
          n_fail++;
          $display("FAIL small_model[%0d]: got %0d want %0d", idx, out2, want);
        end
        if (idx >= 2) begin
          n_run++;
          if (int'(out2) !== 31) begin
            n_fail++; $display("FAIL small_steady[%0d]: got %0d want 31", idx, out2);
          end
        end
        n_run++;
        if (idx == 0) begin
          if (t !== 19) begin
            n_fail++; $display("FAIL small_latency: got %0d want 19", t);
          end
        end else if (t - last !== 16) begin
          n_fail++; $display("FAIL small_cadence: got %0d want 16", t - last);
        end
        last = t;
        idx++;
      end
    end
    n_run++;
    if (idx !== 7 || ovf2 !== 1'b0) begin
      n_fail++; $display("FAIL small_count: got n=%0d o=%b want n=7 o=0", idx, ovf2);
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_pattern(0, 127);
    test_pattern(1, -128);
    test_pattern(2, 0);
    test_pattern(3, 64);
    test_random();
    test_en_gap();
    test_overrun();
    test_ready_same_edge();
    test_reset_mid();
    test_small_config();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
